// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode, FP op and issue-controller state definitions
//
// Purpose : Constants shared by the 16-bit pipelined processor and the
//           floating-point issue controller.
// Contents: opcode constants (ADDF, MULTF, STOP), FP op encodings that drive
//           the FPU op select, the issue-controller state enum, and a helper
//           that maps an opcode to its FP op encoding.

package cpu_pkg;

    localparam logic [3:0] OPC_ADDF  = 4'b1000;
    localparam logic [3:0] OPC_MULTF = 4'b1001;
    localparam logic [3:0] OPC_STOP  = 4'b0111;

    localparam logic FP_OP_ADD  = 1'b0;
    localparam logic FP_OP_MULT = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WB    = 3'd3,
        ST_HALT  = 3'd4
    } fp_state_e;

    // MULTF differs from ADDF only in opcode bit 0, which is the FP op select.
    function automatic logic fp_op_of(input logic [3:0] opc);
        return (opc == OPC_MULTF) ? FP_OP_MULT : FP_OP_ADD;
    endfunction

endpackage

// File: rtl/fp_issue_ctrl_if.sv
// rtl/fp_issue_ctrl_if.sv - start/ready/done handshake between issue controller and FPU
//
// Purpose : Groups the FPU handshake signals.
// Signals : fpu_start  controller -> FPU  start request
//           fpu_op     controller -> FPU  0 = add, 1 = multiply
//           fpu_ready  FPU -> controller  start accepted this cycle
//           fpu_done   FPU -> controller  result valid, one-cycle pulse
//           fpu_result FPU -> controller  DATA_WIDTH result
// Modports: master (issue controller), slave (FPU).

interface fp_issue_ctrl_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  fpu_start;
    logic                  fpu_op;
    logic                  fpu_ready;
    logic                  fpu_done;
    logic [DATA_WIDTH-1:0] fpu_result;

    modport master (
        output fpu_start,
        output fpu_op,
        input  fpu_ready,
        input  fpu_done,
        input  fpu_result
    );

    modport slave (
        input  fpu_start,
        input  fpu_op,
        output fpu_ready,
        output fpu_done,
        output fpu_result
    );
endinterface

// File: rtl/fp_watchdog.sv
// rtl/fp_watchdog.sv - load/count/expire cycle counter for the FPU wait timeout
//
// Purpose : Counts enabled cycles after a load; expire_o is high during the
//           TIMEOUT-th enabled cycle since the load.
// Ports   : clk, rst (sync, active-high)
//           load_i   clear the count to zero
//           en_i     count this cycle
//           expire_o TIMEOUT enabled cycles reached (combinational)

module fp_watchdog #(
    parameter int TIMEOUT = 64,
    localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic en_i,
    output logic expire_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expire_o = en_i && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (en_i && !expire_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fp_issue_ctrl.sv
// rtl/fp_issue_ctrl.sv - multi-cycle issue controller for the shared floating-point unit
//
// Purpose : Detects ADDF/MULTF in EX, freezes the pipeline, starts the FPU via
//           start/ready, waits for done, writes the result back through a
//           dedicated registered port and releases the pipeline. Also latches
//           a permanent halt on STOP.
// Config  : FP_TIMEOUT_EN - when defined, a watchdog bounds the WAIT state to
//           TIMEOUT cycles; on expiry fp_err_o is set (sticky) and the
//           controller halts without writeback. Undefined: WAIT is unbounded
//           and fp_err_o is tied 0.
// Ports   : clk, rst            sync active-high reset
//           ex_valid_i, ex_floating_i, ex_op_i, ex_stop_i, ex_rd_i  EX stage info
//           fpu                 FPU handshake (fp_issue_ctrl_if.master)
//           stall_o             freeze PC, IF/ID, ID/EX
//           wb_en_o/wb_rd_o/wb_data_o  registered FP writeback
//           halted_o            processor halted
//           fp_err_o            sticky FPU timeout error

module fp_issue_ctrl
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int RD_WIDTH   = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid_i,
    input  logic                  ex_floating_i,
    input  logic                  ex_op_i,
    input  logic                  ex_stop_i,
    input  logic [RD_WIDTH-1:0]   ex_rd_i,
    fp_issue_ctrl_if.master       fpu,
    output logic                  stall_o,
    output logic                  wb_en_o,
    output logic [RD_WIDTH-1:0]   wb_rd_o,
    output logic [DATA_WIDTH-1:0] wb_data_o,
    output logic                  halted_o,
    output logic                  fp_err_o
);

    fp_state_e             state_q, state_d;
    logic                  op_q, op_d;
    logic [RD_WIDTH-1:0]   rd_q, rd_d;
    logic                  wb_en_q, wb_en_d;
    logic [RD_WIDTH-1:0]   wb_rd_q, wb_rd_d;
    logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
    logic                  start;
    logic                  stall;

`ifdef FP_TIMEOUT_EN
    logic err_q, err_d;
    logic wd_load;
    logic wd_en;
    logic wd_expire;

    fp_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .load_i   (wd_load),
        .en_i     (wd_en),
        .expire_o (wd_expire)
    );
`endif

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rd_d      = rd_q;
        wb_en_d   = 1'b0;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        start     = 1'b0;
        stall     = 1'b0;
`ifdef FP_TIMEOUT_EN
        err_d     = err_q;
        wd_load   = 1'b0;
        wd_en     = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                // The detecting cycle itself must be frozen, so stall here is
                // combinational on the EX inputs. STOP wins over Floating.
                if (ex_valid_i && ex_stop_i) begin
                    stall   = 1'b1;
                    state_d = ST_HALT;
                end else if (ex_valid_i && ex_floating_i) begin
                    stall   = 1'b1;
                    op_d    = ex_op_i;
                    rd_d    = ex_rd_i;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // fpu_done is deliberately not looked at here.
                start = 1'b1;
                stall = 1'b1;
                if (fpu.fpu_ready) begin
                    state_d = ST_WAIT;
`ifdef FP_TIMEOUT_EN
                    wd_load = 1'b1;
`endif
                end
            end
            ST_WAIT: begin
                stall = 1'b1;
`ifdef FP_TIMEOUT_EN
                wd_en = 1'b1;
`endif
                if (fpu.fpu_done) begin
                    wb_en_d   = 1'b1;
                    wb_rd_d   = rd_q;
                    wb_data_d = fpu.fpu_result;
                    state_d   = ST_WB;
                end
`ifdef FP_TIMEOUT_EN
                else if (wd_expire) begin
                    err_d   = 1'b1;
                    state_d = ST_HALT;
                end
`endif
            end
            ST_WB: begin
                // The FP instruction leaves EX on this edge; going straight to
                // IDLE means the next EX instruction is the first one examined.
                state_d = ST_IDLE;
            end
            ST_HALT: begin
                stall = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_q      <= FP_OP_ADD;
            rd_q      <= '0;
            wb_en_q   <= 1'b0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
`ifdef FP_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            wb_en_q   <= wb_en_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
`ifdef FP_TIMEOUT_EN
            err_q     <= err_d;
`endif
        end
    end

    assign fpu.fpu_start = start;
    assign fpu.fpu_op    = op_q;
    assign stall_o       = stall;
    assign wb_en_o       = wb_en_q;
    assign wb_rd_o       = wb_rd_q;
    assign wb_data_o     = wb_data_q;
    assign halted_o      = (state_q == ST_HALT);
`ifdef FP_TIMEOUT_EN
    assign fp_err_o      = err_q;
`else
    assign fp_err_o      = 1'b0;
`endif

endmodule

// File: tb/tb_fp_issue_ctrl.sv
// tb/tb_fp_issue_ctrl.sv - directed self-checking bench for fp_issue_ctrl

module tb_fp_issue_ctrl;

    localparam int DW = 16;
    localparam int RW = 4;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ex_valid = 1'b0;
    logic          ex_floating = 1'b0;
    logic          ex_op = 1'b0;
    logic          ex_stop = 1'b0;
    logic [RW-1:0] ex_rd = '0;
    logic          stall;
    logic          wb_en;
    logic [RW-1:0] wb_rd;
    logic [DW-1:0] wb_data;
    logic          halted;
    logic          fp_err;

    int n_checks = 0;
    int n_errors = 0;
    int accepts  = 0;
    int wbs      = 0;

    fp_issue_ctrl_if #(.DATA_WIDTH(DW)) fpu_if ();

    fp_issue_ctrl #(
        .DATA_WIDTH (DW),
        .RD_WIDTH   (RW),
        .TIMEOUT    (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ex_valid_i    (ex_valid),
        .ex_floating_i (ex_floating),
        .ex_op_i       (ex_op),
        .ex_stop_i     (ex_stop),
        .ex_rd_i       (ex_rd),
        .fpu           (fpu_if),
        .stall_o       (stall),
        .wb_en_o       (wb_en),
        .wb_rd_o       (wb_rd),
        .wb_data_o     (wb_data),
        .halted_o      (halted),
        .fp_err_o      (fp_err)
    );

    always #5 clk = ~clk;

    // Accepted starts and writebacks, counted at the active edge.
    always @(posedge clk) begin
        if (!rst && fpu_if.fpu_start && fpu_if.fpu_ready) accepts <= accepts + 1;
        if (!rst && wb_en) wbs <= wbs + 1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic v, input logic f, input logic op, input logic s, input logic [RW-1:0] rd);
        ex_valid = v; ex_floating = f; ex_op = op; ex_stop = s; ex_rd = rd;
    endtask

    task automatic set_fpu(input logic rdy, input logic dn, input logic [DW-1:0] res);
        fpu_if.fpu_ready = rdy; fpu_if.fpu_done = dn; fpu_if.fpu_result = res;
    endtask

    task automatic check_zero(input string tag);
        #1;
        check({tag, "_stall"},  stall,            0);
        check({tag, "_start"},  fpu_if.fpu_start, 0);
        check({tag, "_op"},     fpu_if.fpu_op,    0);
        check({tag, "_wb_en"},  wb_en,            0);
        check({tag, "_wb_rd"},  wb_rd,            0);
        check({tag, "_wb_dat"}, wb_data,          0);
        check({tag, "_halt"},   halted,           0);
        check({tag, "_err"},    fp_err,           0);
    endtask

    task automatic do_reset(input string tag);
        set_ex(0, 0, 0, 0, 0);
        set_fpu(0, 0, 0);
        rst = 1'b1;
        cyc();
        cyc();
        check_zero(tag);
        rst = 1'b0;
    endtask

    int a0;
    int w0;

    initial begin
        set_fpu(0, 0, 0);
        do_reset("rst");

        // ADDF rd5, ready at T+1, done at T+4
        cyc(); set_ex(1, 1, 0, 0, 4'd5); #1;
        check("add_T_stall", stall, 1);
        check("add_T_start", fpu_if.fpu_start, 0);
        cyc(); set_fpu(1, 0, 0); #1;
        check("add_T1_start", fpu_if.fpu_start, 1);
        check("add_T1_op", fpu_if.fpu_op, 0);
        cyc(); set_fpu(0, 0, 0); #1;
        check("add_T2_start", fpu_if.fpu_start, 0);
        check("add_T2_stall", stall, 1);
        cyc(); #1;
        check("add_T3_stall", stall, 1);
        cyc(); set_fpu(0, 1, 16'h3C00); #1;
        check("add_T4_stall", stall, 1);
        check("add_T4_wb_en", wb_en, 0);
        cyc(); set_fpu(0, 0, 0); #1;
        check("add_T5_wb_en", wb_en, 1);
        check("add_T5_wb_rd", wb_rd, 5);
        check("add_T5_wb_data", wb_data, 16'h3C00);
        check("add_T5_stall", stall, 0);
        cyc(); set_ex(0, 0, 0, 0, 0); #1;
        check("add_T6_wb_en", wb_en, 0);
        check("add_T6_stall", stall, 0);
        cyc(); #1;
        check("add_T7_start", fpu_if.fpu_start, 0);

        // MULTF rd9, ready withheld for 3 cycles
        cyc(); set_ex(1, 1, 1, 0, 4'd9); #1;
        check("mul_T_stall", stall, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(); #1;
            check("mul_hold_start", fpu_if.fpu_start, 1);
            check("mul_hold_op", fpu_if.fpu_op, 1);
        end
        cyc(); set_fpu(1, 0, 0); #1;
        check("mul_acc_start", fpu_if.fpu_start, 1);
        check("mul_acc_op", fpu_if.fpu_op, 1);
        cyc(); set_fpu(0, 0, 0); #1;
        check("mul_wait_start", fpu_if.fpu_start, 0);
        check("mul_wait_op", fpu_if.fpu_op, 1);
        check("mul_wait_stall", stall, 1);
        cyc(); set_fpu(0, 1, 16'h4200); #1;
        cyc(); set_fpu(0, 0, 0); #1;
        check("mul_wb_en", wb_en, 1);
        check("mul_wb_rd", wb_rd, 9);
        check("mul_wb_data", wb_data, 16'h4200);
        cyc(); set_ex(0, 0, 0, 0, 0); #1;
        check("mul_after_stall", stall, 0);

        // Two back-to-back ADDFs, done two cycles after accept
        a0 = accepts; w0 = wbs;
        cyc(); set_ex(1, 1, 0, 0, 4'd3); #1;
        cyc(); set_fpu(1, 0, 0); #1;
        cyc(); set_fpu(0, 0, 0); #1;
        cyc(); set_fpu(0, 1, 16'h1111); #1;
        cyc(); set_fpu(0, 0, 0); #1;
        check("b2b1_wb_en", wb_en, 1);
        check("b2b1_wb_rd", wb_rd, 3);
        check("b2b1_wb_data", wb_data, 16'h1111);
        cyc(); set_ex(1, 1, 0, 0, 4'd7); #1;
        check("b2b2_detect_stall", stall, 1);
        check("b2b2_detect_wb_en", wb_en, 0);
        cyc(); set_fpu(1, 0, 0); #1;
        check("b2b2_start", fpu_if.fpu_start, 1);
        cyc(); set_fpu(0, 0, 0); #1;
        cyc(); set_fpu(0, 1, 16'h2222); #1;
        cyc(); set_fpu(0, 0, 0); #1;
        check("b2b2_wb_en", wb_en, 1);
        check("b2b2_wb_rd", wb_rd, 7);
        check("b2b2_wb_data", wb_data, 16'h2222);
        cyc(); set_ex(0, 0, 0, 0, 0); #1;
        cyc(); #1;
        check("b2b_accepts", accepts - a0, 2);
        check("b2b_wbs", wbs - w0, 2);

        // Reset during WAIT, then a late done
        w0 = wbs;
        cyc(); set_ex(1, 1, 1, 0, 4'd2); #1;
        cyc(); set_fpu(1, 0, 0); #1;
        cyc(); set_fpu(0, 0, 0); set_ex(0, 0, 0, 0, 0); rst = 1'b1; #1;
        cyc(); rst = 1'b0; set_fpu(0, 1, 16'hBEEF);
        check_zero("rstwait");
        cyc(); set_fpu(0, 0, 0);
        check_zero("rstwait_late");
        check("rstwait_wbs", wbs - w0, 0);

        // No done: WAIT runs T+2..T+9; timeout build halts at T+10
        w0 = wbs;
        cyc(); set_ex(1, 1, 0, 0, 4'd4); #1;
        cyc(); set_fpu(1, 0, 0); #1;
        cyc(); set_fpu(0, 0, 0); #1;
        for (int i = 0; i < 7; i++) begin
            cyc(); #1;
        end
        check("to_T9_halt", halted, 0);
        check("to_T9_err", fp_err, 0);
        cyc(); #1;
        check("to_T10_stall", stall, 1);
`ifdef FP_TIMEOUT_EN
        check("to_T10_halt", halted, 1);
        check("to_T10_err", fp_err, 1);
`else
        check("to_T10_halt", halted, 0);
        check("to_T10_err", fp_err, 0);
`endif
        for (int i = 0; i < 5; i++) begin
            cyc(); #1;
        end
        check("to_late_stall", stall, 1);
        check("to_wbs", wbs - w0, 0);
`ifdef FP_TIMEOUT_EN
        check("to_late_err", fp_err, 1);
`else
        check("to_late_err", fp_err, 0);
`endif
        do_reset("rst_to");

        // STOP in IDLE
        cyc(); set_ex(1, 0, 0, 1, 0); #1;
        check("stop_T_stall", stall, 1);
        check("stop_T_halt", halted, 0);
        cyc(); set_ex(0, 0, 0, 0, 0); #1;
        check("stop_T1_halt", halted, 1);
        check("stop_T1_stall", stall, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(); set_ex(1, 1, 0, 0, 4'd1); #1;
            check("stop_hold_halt", halted, 1);
            check("stop_hold_start", fpu_if.fpu_start, 0);
        end
        do_reset("rst_stop");

        // STOP together with Floating: stop wins
        cyc(); set_ex(1, 1, 1, 1, 4'd6); #1;
        check("stopf_T_stall", stall, 1);
        check("stopf_T_start", fpu_if.fpu_start, 0);
        cyc(); set_fpu(1, 0, 0); #1;
        check("stopf_T1_halt", halted, 1);
        check("stopf_T1_start", fpu_if.fpu_start, 0);
        check("stopf_T1_stall", stall, 1);
        cyc(); set_fpu(0, 1, 16'h1234); #1;
        check("stopf_T2_wb_en", wb_en, 0);
        do_reset("rst_stopf");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
